// File: rtl/cl_line_capture.sv
// Camera Link line capture: thresholded binary line plus raw MSB bit-planes, one commit strobe per line.
// Optional ROI commit window enabled by defining CL_CAPTURE_ROI_EN (adds iROI_Y0 / iROI_Y1).
module cl_line_capture #(
    parameter int PIX_PER_CLK = 2,
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_WIDTH  = 640,
    parameter int ADDR_WIDTH  = 11,
    parameter int NUM_PLANES  = 5
) (
    input  logic                               CCLK,
    input  logic                               RST,
    input  logic                               iVSYNC,
    input  logic                               iDE,
    input  logic [PIX_PER_CLK*PIXEL_WIDTH-1:0] iDATA,
    input  logic [PIXEL_WIDTH-1:0]             iTHRESHOLD,
    input  logic                               iMEM_SEL,
`ifdef CL_CAPTURE_ROI_EN
    input  logic [ADDR_WIDTH-1:0]              iROI_Y0,
    input  logic [ADDR_WIDTH-1:0]              iROI_Y1,
`endif
    output logic                               oWEA,
    output logic                               oWEB,
    output logic [ADDR_WIDTH-1:0]              oCL_ROW,
    output logic                               oLINE_VLD,
    output logic [LINE_WIDTH-1:0]              oBIN_LINE,
    output logic [NUM_PLANES*LINE_WIDTH-1:0]   oPLANES,
    output logic [15:0]                        oFRAME_CNT,
    output logic                               oOVF
);

    // state     | meaning
    // IDLE      | outside a frame, waiting for iVSYNC rise
    // WAIT_LINE | in frame, waiting for the next iDE rise (line start)
    // CAPTURE   | storing pixels of the current line
    // COMMIT    | single cycle presenting the finished line to the line memories
    typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE, COMMIT} state_t;

    localparam int WORDS = LINE_WIDTH / PIX_PER_CLK;
    localparam int WI_W  = $clog2(WORDS + 1);

    state_t state, state_nxt;
    logic   vs_q, de_q;
    logic   vs_rise, de_rise;
    logic   mem_sel;
    logic   line_start, capture_more;
    logic   commit, roi_ok;
    logic [WI_W-1:0] col_word;
    logic [PIX_PER_CLK-1:0] bin_bits;
    logic [NUM_PLANES-1:0][PIX_PER_CLK-1:0] plane_bits;

    assign vs_rise = iVSYNC & ~vs_q;
    assign de_rise = iDE & ~de_q;

`ifdef CL_CAPTURE_ROI_EN
    assign roi_ok = (oCL_ROW >= iROI_Y0) && (oCL_ROW <= iROI_Y1);
`else
    assign roi_ok = 1'b1;
`endif

    always_comb begin
        bin_bits   = '0;
        plane_bits = '0;
        for (int i = 0; i < PIX_PER_CLK; i++) begin
            bin_bits[i] = iDATA[i*PIXEL_WIDTH +: PIXEL_WIDTH] > iTHRESHOLD;
            for (int k = 0; k < NUM_PLANES; k++)
                plane_bits[k][i] = iDATA[i*PIXEL_WIDTH + PIXEL_WIDTH - 1 - k];
        end
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // A line only starts on an iDE rise, so a line cut by a frame restart is never resumed mid-way.
    always_comb begin
        state_nxt = state;
        if (vs_rise) begin
            state_nxt = WAIT_LINE;
        end else begin
            case (state)
                IDLE:      state_nxt = IDLE;
                WAIT_LINE: if (!iVSYNC) state_nxt = IDLE;
                           else if (de_rise) state_nxt = CAPTURE;
                CAPTURE:   if (!iVSYNC) state_nxt = IDLE;
                           else if (!iDE) state_nxt = COMMIT;
                COMMIT:    if (!iVSYNC) state_nxt = IDLE;
                           else if (de_rise) state_nxt = CAPTURE;
                           else state_nxt = WAIT_LINE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        commit    = 1'b0;
        if (state == COMMIT) commit = roi_ok;
        oLINE_VLD = commit;
        oWEA      = commit & ~mem_sel;
        oWEB      = commit & mem_sel;
    end

    assign line_start   = (state_nxt == CAPTURE) && (state != CAPTURE);
    assign capture_more = (state_nxt == CAPTURE) && (state == CAPTURE);

    // Held high out of reset so a frame already in progress is not mistaken for a new one.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            vs_q <= 1'b1;
            de_q <= 1'b0;
        end else begin
            vs_q <= iVSYNC;
            de_q <= iDE;
        end
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            mem_sel    <= 1'b0;
            oCL_ROW    <= '0;
            oFRAME_CNT <= '0;
            oOVF       <= 1'b0;
        end else if (vs_rise) begin
            mem_sel    <= iMEM_SEL;
            oCL_ROW    <= '0;
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
            oOVF       <= 1'b0;
        end else begin
            if (state == COMMIT) oCL_ROW <= oCL_ROW + 1'b1;
            if (capture_more && col_word >= WI_W'(WORDS)) oOVF <= 1'b1;
        end
    end

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            col_word  <= '0;
            oBIN_LINE <= '0;
            oPLANES   <= '0;
        end else if (line_start) begin
            oBIN_LINE <= '0;
            oPLANES   <= '0;
            oBIN_LINE[PIX_PER_CLK-1:0] <= bin_bits;
            for (int k = 0; k < NUM_PLANES; k++)
                oPLANES[k*LINE_WIDTH +: PIX_PER_CLK] <= plane_bits[k];
            col_word  <= WI_W'(1);
        end else if (capture_more && col_word < WI_W'(WORDS)) begin
            for (int w = 0; w < WORDS; w++) begin
                if (col_word == WI_W'(w)) begin
                    oBIN_LINE[w*PIX_PER_CLK +: PIX_PER_CLK] <= bin_bits;
                    for (int k = 0; k < NUM_PLANES; k++)
                        oPLANES[k*LINE_WIDTH + w*PIX_PER_CLK +: PIX_PER_CLK] <= plane_bits[k];
                end
            end
            col_word <= col_word + 1'b1;
        end
    end

endmodule

// File: tb/tb_cl_line_capture.sv
// Self-checking bench for cl_line_capture: frame table plus hand-written abort/reset sequences,
// with expected lines computed per pixel from the threshold and bit-plane rules.
module tb_cl_line_capture;
    localparam int PPC = 2;
    localparam int PW  = 8;
    localparam int LW  = 640;
    localparam int AW  = 11;
    localparam int NP  = 5;

    logic              CCLK;
    logic              RST;
    logic              iVSYNC;
    logic              iDE;
    logic [PPC*PW-1:0] iDATA;
    logic [PW-1:0]     iTHRESHOLD;
    logic              iMEM_SEL;
    logic              oWEA, oWEB, oLINE_VLD, oOVF;
    logic [AW-1:0]     oCL_ROW;
    logic [LW-1:0]     oBIN_LINE;
    logic [NP*LW-1:0]  oPLANES;
    logic [15:0]       oFRAME_CNT;

    cl_line_capture #(.PIX_PER_CLK(PPC), .PIXEL_WIDTH(PW), .LINE_WIDTH(LW),
                      .ADDR_WIDTH(AW), .NUM_PLANES(NP)) dut (
        .CCLK(CCLK), .RST(RST), .iVSYNC(iVSYNC), .iDE(iDE), .iDATA(iDATA),
        .iTHRESHOLD(iTHRESHOLD), .iMEM_SEL(iMEM_SEL), .oWEA(oWEA), .oWEB(oWEB),
        .oCL_ROW(oCL_ROW), .oLINE_VLD(oLINE_VLD), .oBIN_LINE(oBIN_LINE),
        .oPLANES(oPLANES), .oFRAME_CNT(oFRAME_CNT), .oOVF(oOVF));

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    typedef struct {
        logic [AW-1:0]    row;
        logic             bank;
        logic [LW-1:0]    bin;
        logic [NP*LW-1:0] planes;
    } exp_t;

    typedef struct {
        logic msel;
        int   nlines;
        int   beats;
        int   gap;
        int   pat;
        int   thr;
        logic exp_ovf;
        int   exp_wea;
        int   exp_web;
    } frame_vec_t;

    int   checks = 0;
    int   errors = 0;
    int   wea_cnt = 0;
    int   web_cnt = 0;
    exp_t exp_q[$];
    int   exp_fc;
    logic [AW-1:0] exp_row;
    logic exp_bank;
    frame_vec_t tbl[6];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic observe();
        exp_t e;
        chk("we_exclusive", LW'(oWEA & oWEB), '0);
        chk("vld_matches_we", LW'(oWEA | oWEB), LW'(oLINE_VLD));
        if (oLINE_VLD) begin
            wea_cnt += int'(oWEA);
            web_cnt += int'(oWEB);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe row %0d wea %0b web %0b", oCL_ROW, oWEA, oWEB);
            end else begin
                e = exp_q.pop_front();
                chk("commit_row", LW'(oCL_ROW), LW'(e.row));
                chk("commit_bank_b", LW'(oWEB), LW'(e.bank));
                chk("commit_bin", oBIN_LINE, e.bin);
                for (int k = 0; k < NP; k++)
                    chk($sformatf("commit_plane%0d", k), oPLANES[k*LW +: LW], e.planes[k*LW +: LW]);
            end
        end
    endtask

    task automatic cyc(input logic vs, input logic de, input logic [PPC*PW-1:0] d);
        iVSYNC = vs;
        iDE    = de;
        iDATA  = d;
        @(negedge CCLK);
        observe();
    endtask

    task automatic frame_start(input logic msel);
        iMEM_SEL = msel;
        cyc(1'b1, 1'b0, 16'($urandom));
        cyc(1'b1, 1'b0, 16'($urandom));
        exp_fc++;
        exp_row  = '0;
        exp_bank = msel;
        chk("start_frame_cnt", LW'(oFRAME_CNT), LW'(16'(exp_fc)));
        chk("start_ovf_clear", LW'(oOVF), '0);
        chk("start_row_zero", LW'(oCL_ROW), '0);
    endtask

    task automatic frame_end();
        repeat (3) cyc(1'b0, 1'b0, '0);
    endtask

    // One full line; the expected commit is queued before blanking so a 1-cycle gap is observed in order.
    task automatic send_line(input int beats, input int gap, input int pat, input logic [PW-1:0] thr);
        logic [PW-1:0] pix [700];
        exp_t e;
        for (int p = 0; p < beats*PPC; p++)
            pix[p] = (pat == 1) ? ((p % 2 == 0) ? 8'h80 : 8'h10) : 8'($urandom);
        iTHRESHOLD = thr;
        for (int b = 0; b < beats; b++) begin
            iMEM_SEL = 1'($urandom);
            cyc(1'b1, 1'b1, {pix[2*b+1], pix[2*b]});
        end
        e.row    = exp_row;
        e.bank   = exp_bank;
        e.bin    = '0;
        e.planes = '0;
        for (int p = 0; p < beats*PPC && p < LW; p++) begin
            e.bin[p] = pix[p] > thr;
            for (int k = 0; k < NP; k++)
                e.planes[k*LW + p] = pix[p][PW-1-k];
        end
        exp_q.push_back(e);
        exp_row = exp_row + 1'b1;
        for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, 16'($urandom));
    endtask

    initial begin
        logic [LW-1:0] alt;
        int base_a, base_b;
        logic [PW-1:0] thr;

        tbl[0] = '{1'b0, 3, 320, 5, 1, 64, 1'b0, 3, 0};
        tbl[1] = '{1'b1, 2, 350, 4, 0, -1, 1'b1, 0, 2};
        tbl[2] = '{1'b0, 4, 100, 1, 0, -1, 1'b0, 4, 0};
        tbl[3] = '{1'b1, 3, 320, 1, 0, -1, 1'b0, 0, 3};
        tbl[4] = '{1'b0, 2, 319, 3, 0, -1, 1'b0, 2, 0};
        tbl[5] = '{1'b1, 2, 320, 2, 1, -1, 1'b0, 0, 2};
        for (int p = 0; p < LW; p++) alt[p] = (p % 2 == 0);

        RST = 1'b1; iVSYNC = 1'b0; iDE = 1'b0; iDATA = '0; iTHRESHOLD = '0; iMEM_SEL = 1'b0;
        #1;
        chk("rst_wea", LW'(oWEA), '0);
        chk("rst_web", LW'(oWEB), '0);
        chk("rst_vld", LW'(oLINE_VLD), '0);
        chk("rst_row", LW'(oCL_ROW), '0);
        chk("rst_bin", oBIN_LINE, '0);
        chk("rst_planes", LW'(|oPLANES), '0);
        chk("rst_frame_cnt", LW'(oFRAME_CNT), '0);
        chk("rst_ovf", LW'(oOVF), '0);
        repeat (3) @(negedge CCLK);
        RST = 1'b0;
        exp_fc = 0;
        repeat (2) cyc(1'b0, 1'b0, '0);

        for (int i = 0; i < 6; i++) begin
            base_a = wea_cnt;
            base_b = web_cnt;
            frame_start(tbl[i].msel);
            for (int l = 0; l < tbl[i].nlines; l++) begin
                thr = (tbl[i].thr < 0) ? 8'($urandom) : 8'(tbl[i].thr);
                send_line(tbl[i].beats, tbl[i].gap, tbl[i].pat, thr);
            end
            frame_end();
            chk($sformatf("f%0d_frame_cnt", i), LW'(oFRAME_CNT), LW'(16'(exp_fc)));
            chk($sformatf("f%0d_ovf", i), LW'(oOVF), LW'(tbl[i].exp_ovf));
            chk($sformatf("f%0d_wea_pulses", i), LW'(wea_cnt - base_a), LW'(tbl[i].exp_wea));
            chk($sformatf("f%0d_web_pulses", i), LW'(web_cnt - base_b), LW'(tbl[i].exp_web));
            chk($sformatf("f%0d_final_row", i), LW'(oCL_ROW), LW'(tbl[i].nlines));
            chk($sformatf("f%0d_pending", i), LW'(exp_q.size()), '0);
            exp_q.delete();
            if (tbl[i].pat == 1 && tbl[i].thr == 64) begin
                chk("alt_bin", oBIN_LINE, alt);
                chk("alt_plane0", oPLANES[0 +: LW], alt);
                chk("alt_plane4", oPLANES[4*LW +: LW], '0);
            end
        end

        // Frame restart in the middle of a line, bank B selected at the restart.
        base_a = wea_cnt;
        base_b = web_cnt;
        frame_start(1'b0);
        iTHRESHOLD = 8'($urandom);
        repeat (50) cyc(1'b1, 1'b1, 16'($urandom));
        cyc(1'b0, 1'b1, 16'($urandom));
        iMEM_SEL = 1'b1;
        cyc(1'b1, 1'b1, 16'($urandom));
        exp_fc++;
        exp_row  = '0;
        exp_bank = 1'b1;
        repeat (49) cyc(1'b1, 1'b1, 16'($urandom));
        repeat (3) cyc(1'b1, 1'b0, 16'($urandom));
        send_line(320, 4, 0, 8'($urandom));
        frame_end();
        chk("restart_frame_cnt", LW'(oFRAME_CNT), LW'(16'(exp_fc)));
        chk("restart_wea_pulses", LW'(wea_cnt - base_a), '0);
        chk("restart_web_pulses", LW'(web_cnt - base_b), LW'(1));
        chk("restart_row", LW'(oCL_ROW), LW'(1));
        chk("restart_pending", LW'(exp_q.size()), '0);
        exp_q.delete();

        // Asynchronous reset while capturing; capture must wait for a fresh iVSYNC rise.
        frame_start(1'b0);
        repeat (100) cyc(1'b1, 1'b1, 16'($urandom));
        #2 RST = 1'b1;
        #1;
        chk("arst_frame_cnt", LW'(oFRAME_CNT), '0);
        chk("arst_bin", oBIN_LINE, '0);
        chk("arst_planes", LW'(|oPLANES), '0);
        chk("arst_row", LW'(oCL_ROW), '0);
        chk("arst_strobes", LW'({oWEA, oWEB, oLINE_VLD}), '0);
        @(negedge CCLK);
        RST = 1'b0;
        exp_fc = 0;
        repeat (50) cyc(1'b1, 1'b1, 16'($urandom));
        repeat (5) cyc(1'b1, 1'b0, 16'($urandom));
        repeat (320) cyc(1'b1, 1'b1, 16'($urandom));
        repeat (5) cyc(1'b1, 1'b0, 16'($urandom));
        chk("post_rst_frame_cnt", LW'(oFRAME_CNT), '0);
        chk("post_rst_bin", oBIN_LINE, '0);
        frame_end();
        base_a = wea_cnt;
        base_b = web_cnt;
        frame_start(1'b1);
        send_line(320, 3, 0, 8'($urandom));
        frame_end();
        chk("resume_frame_cnt", LW'(oFRAME_CNT), LW'(1));
        chk("resume_web_pulses", LW'(web_cnt - base_b), LW'(1));
        chk("resume_wea_pulses", LW'(wea_cnt - base_a), '0);
        chk("resume_pending", LW'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
